uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

Receive-side controller for the UART receiver in an FPro MMIO slot. It generates the 16x oversampling `s_tick` from a programmable divisor and buffers each byte flagged by the receiver's `rx_done_tick` in a small FIFO. It tracks overrun, drives a level interrupt, and exposes data, status and configuration to the bus through the standard slot interface (`cs`/`read`/`write`/`addr`).

## Interface

- `FIFO_W`, 2, log2 of FIFO depth (depth = 2^FIFO_W = 4).
- `DVSR_W`, 11, divisor register width.
- `DVSR_RST`, 650, divisor after reset (100 MHz clock, 9600 baud, 16x oversampling).

- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: slot select; qualifies `write`.
- `read` in 1: read strobe; no side effects.
- `write` in 1: write strobe.
- `addr` in 5: register address.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data, combinational from `addr`.
- `s_tick` out 1: oversampling tick to the receiver.
- `rx_done_tick` in 1: one-cycle byte-complete pulse from the receiver.
- `rx_dout` in 8: received byte, valid when `rx_done_tick`=1.
- `irq` out 1: level interrupt.

## Operation

- Register map. A write takes effect only when `cs & write`; unlisted addresses read 0 and ignore writes.
  - addr 0, read: [7:0] FIFO head byte (0 when empty), [8] `empty`, [9] `full`, [10] `overrun`, [13:11] occupancy count (0..4; FIFO_W+1 bits), rest 0.
  - addr 1, read/write: [DVSR_W-1:0] `dvsr`. A write also clears the baud counter.
  - addr 2, read/write: [0] `rx_en`. Bit [1] is flush: write-1 only, not stored, reads 0.
  - addr 3, write: pop the FIFO head; `wr_data` is ignored.
  - addr 4, write: if `wr_data[0]`=1, clear `overrun`.
- Baud generator:
  - Counter `bcnt` (DVSR_W bits) holds at 0 while `rx_en`=0; `s_tick` is then 0.
  - Otherwise, when `bcnt==dvsr`: `s_tick`=1 for that cycle and `bcnt` goes to 0; else `bcnt` increments.
  - Tick period is `dvsr+1` cycles. `dvsr`=0 gives a tick every cycle.
  - `s_tick` is a Moore output: `s_tick = rx_en & (bcnt==dvsr)`.
- FIFO: circular buffer with read pointer, write pointer and FIFO_W+1-bit count; pointers wrap modulo depth.
  - Push when `rx_done_tick & rx_en & (~full | pop)`.
  - `rx_done_tick` with `rx_en`=0 is ignored; `overrun` is not set.
  - Pop when the addr-3 write hits and the FIFO is not empty. Pop on empty is ignored, with no state change.
  - Push and pop in the same cycle: both occur and count is unchanged. This includes the full case: no overrun, the new byte lands at the freed slot order-wise (FIFO order is preserved).
  - Push and pop in the same cycle on an empty FIFO: push only.
- Overrun:
  - Set when `rx_done_tick & rx_en & full & ~pop`; the byte is dropped.
  - Sticky until cleared via addr 4. If clear and set occur in the same cycle, set wins.
- Flush (addr 2, bit 1): pointers and count go to 0 the next cycle.
  - A concurrent push is discarded without setting `overrun`.
  - A concurrent pop is ignored.
  - `overrun` is unaffected.
  - `rx_en` takes the written bit 0 in the same write.
- `irq = ~empty | overrun`, registered-state derived, no extra latency.

## Timing

- Reset values:
  - `dvsr`=DVSR_RST, `rx_en`=1, `bcnt`=0.
  - FIFO empty, `overrun`=0.
  - `s_tick`=0 (unless DVSR_RST=0), `irq`=0.
  - `rd_data` at addr 0 = 0x100.
- `reset` mid-operation discards FIFO contents and restores all registers on the next edge, with no partial state.
- Push latency: byte visible at addr 0 and `empty`=0 the cycle after `rx_done_tick`.
- Pop: the next head is visible the cycle after the addr-3 write.
- Divisor write in cycle t: `bcnt`=0 at t+1. First `s_tick` occurs at t+1+new `dvsr`.
- `rx_en` 1->0 write: `s_tick`=0 from the next cycle. `rx_en` 0->1: first tick after `dvsr+1` cycles.
- `read` has no effect on state; reading addr 0 does not pop.

## Test plan

- Reset, then read addr 0 -> 0x100; addr 1 -> 650; addr 2 -> 1; `irq`=0.
- Write `dvsr`=3 and count `s_tick` over 40 cycles -> exactly 10 pulses, spaced 4 cycles apart. Write `dvsr`=0 -> `s_tick` high every cycle.
- Push 0xA5 then 0x3C via `rx_done_tick` -> addr 0 reads 0x8A5 (count 1)... then 0x10A5 (count 2). Pop -> 0x83C. Pop -> 0x100, `irq`=0.
- Push 0x01..0x04 (full, addr 0 = 0x2201), then push 0x05 -> `overrun`=1, addr 0 = 0x2601. Pop all four -> 0x01..0x04 in order. Write addr 4 = 1 -> `overrun`=0.
- FIFO full with a pop and `rx_done_tick` (0x77) in the same cycle -> count stays 4, no overrun, and 0x77 is read after 0x02..0x04.
- Flush with a concurrent push -> next-cycle addr 0 = 0x100, `overrun` unchanged. Write `rx_en`=0 -> `s_tick` stays 0 and pushes are ignored.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// MMIO slot bus between the processor-side master and the uart_rx_ctrl slave.
// rd_data is driven combinationally by the slave from addr.
interface uart_rx_ctrl_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs,
    output read,
    output write,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  cs,
    input  read,
    input  write,
    input  addr,
    input  wr_data,
    output rd_data
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: programmable 16x oversampling tick, byte FIFO with
// overrun tracking, level interrupt and an MMIO register file.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_W   = 2,
  parameter int unsigned DVSR_W   = 11,
  parameter int unsigned DVSR_RST = 650
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_rx_ctrl_if.slave        bus,
  output logic                 s_tick,
  input  logic                 rx_done_tick,
  input  logic [7:0]           rx_dout,
  output logic                 irq
);

  localparam int unsigned Depth = 1 << FIFO_W;

  localparam logic [DVSR_W-1:0] BcntOne = {{(DVSR_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_W-1:0] PtrOne  = {{(FIFO_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_W:0]   CntOne  = {{FIFO_W{1'b0}}, 1'b1};

  logic [DVSR_W-1:0] dvsr_q, dvsr_d;
  logic [DVSR_W-1:0] bcnt_q, bcnt_d;
  logic              rx_en_q, rx_en_d;
  logic              overrun_q, overrun_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W:0]   count_q, count_d;
  logic [7:0]        mem_q [Depth];

  logic       wr_en, wr_dvsr, wr_ctrl, wr_pop, wr_clr;
  logic       flush, empty, full;
  logic       push_req, push, pop, ovr_set;
  logic [7:0] head;
  logic       unused_bus;

  // Register decode
  assign wr_en   = bus.cs & bus.write;
  assign wr_dvsr = wr_en & (bus.addr == 5'd1);
  assign wr_ctrl = wr_en & (bus.addr == 5'd2);
  assign wr_pop  = wr_en & (bus.addr == 5'd3);
  assign wr_clr  = wr_en & (bus.addr == 5'd4) & bus.wr_data[0];
  assign flush   = wr_ctrl & bus.wr_data[1];

  // count never exceeds Depth, so its MSB alone flags full
  assign empty = (count_q == '0);
  assign full  = count_q[FIFO_W];

  // Flush wins over everything: a same-cycle byte is dropped silently and a pop is void.
  assign push_req = rx_done_tick & rx_en_q;
  assign pop      = wr_pop & ~empty & ~flush;
  assign push     = push_req & (~full | pop) & ~flush;
  assign ovr_set  = push_req & full & ~pop & ~flush;

  assign head   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign s_tick = rx_en_q & (bcnt_q == dvsr_q);
  assign irq    = ~empty | overrun_q;

  assign unused_bus = ^{bus.read, bus.wr_data[31:DVSR_W]};

  always_comb begin
    dvsr_d    = dvsr_q;
    rx_en_d   = rx_en_q;
    bcnt_d    = bcnt_q;
    overrun_d = overrun_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;

    if (wr_dvsr) begin
      dvsr_d = bus.wr_data[DVSR_W-1:0];
    end
    if (wr_ctrl) begin
      rx_en_d = bus.wr_data[0];
    end

    if (wr_dvsr || !rx_en_q || (bcnt_q == dvsr_q)) begin
      bcnt_d = '0;
    end else begin
      bcnt_d = bcnt_q + BcntOne;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (wr_clr) begin
      overrun_d = 1'b0;
    end

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvsr_q    <= DVSR_W'(DVSR_RST);
      rx_en_q   <= 1'b1;
      bcnt_q    <= '0;
      overrun_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      dvsr_q    <= dvsr_d;
      rx_en_q   <= rx_en_d;
      bcnt_q    <= bcnt_d;
      overrun_q <= overrun_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= rx_dout;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    case (bus.addr)
      5'd0: begin
        bus.rd_data[7:0]          = head;
        bus.rd_data[8]            = empty;
        bus.rd_data[9]            = full;
        bus.rd_data[10]           = overrun_q;
        bus.rd_data[11 +: FIFO_W+1] = count_q;
      end
      5'd1:    bus.rd_data[DVSR_W-1:0] = dvsr_q;
      5'd2:    bus.rd_data[0] = rx_en_q;
      default: bus.rd_data = '0;
    endcase
  end

endmodule
